hangman_round_ctrl: RTL

//  Parametrised multi-round game engine for the hangman design. Sits between keyboard_handler
//  (load/letter) and vga_handler (guessed_mask/state/wrong count); drives the word-RAM address.

---
 rtl/hangman_pkg.sv | 21 ++
 rtl/hangman_guess_timer.sv | 45 ++++
 rtl/hangman_round_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman round controller.
//   game_state_e    : 2-bit game state encoding seen by the display side
//   DEF_ALPHABET/LW : default alphabet size and letter-code width
//   letter_in_range : true when a letter code addresses a tracked letter
package hangman_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'b00,
    ST_WIN  = 2'b01,
    ST_LOSE = 2'b10,
    ST_LOAD = 2'b11
  } game_state_e;

  localparam int DEF_ALPHABET = 26;
  localparam int DEF_LW       = 5;

  function automatic logic letter_in_range(input int unsigned code, input int unsigned alphabet);
    return code < alphabet;
  endfunction

endpackage

// File: rtl/hangman_guess_timer.sv
// Per-guess idle timer, used only when HANGMAN_TIMEOUT_EN is defined.
// Down-counter reloaded to TIMEOUT_CYC-1 whenever it is not running, on a
// restart, and after reaching zero. expire_o flags the terminal-count cycle
// unless a restart arrives in that same cycle.
// Ports:
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   run_i     : count enable (round in progress)
//   restart_i : accepted guess; reload without expiring
//   expire_o  : one-cycle expiry flag
module hangman_guess_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic restart_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || restart_i || (cnt_q == '0)) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire_o = run_i && (cnt_q == '0) && !restart_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hangman_round_ctrl.sv
// Multi-round hangman game engine between the keyboard and display blocks.
// Tracks guessed letters, wrong guesses, repeat guesses, round sequencing
// (with a wait for the word RAM to settle) and a saturating win streak.
// Optional per-guess timeout: define HANGMAN_TIMEOUT_EN.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   load_i, load_x_i : guess strobe and letter code (0 = 'A')
//   mask_i           : letters present in the current word
//   next_round_i     : advance to the next word (WIN/LOSE only)
//   word_select_o    : word RAM address
//   guessed_mask_o   : letters guessed this round
//   game_state_o     : 00 PLAY, 01 WIN, 10 LOSE, 11 LOAD
//   wrong_o          : pulse per wrong guess
//   repeat_guess_o   : pulse on an already-guessed letter
//   wrong_time_o     : wrong guesses this round
//   score_o          : consecutive wins, saturating
module hangman_round_ctrl
  import hangman_pkg::*;
#(
  parameter int ALPHABET    = DEF_ALPHABET,
  parameter int LW          = DEF_LW,
  parameter int MAX_WRONG   = 6,
  parameter int WW          = 4,
  parameter int NUM_WORDS   = 16,
  parameter int SELW        = 4,
  parameter int RAM_LAT     = 2,
  parameter int SCORE_W     = 8,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [LW-1:0]       load_x_i,
  input  logic [ALPHABET-1:0] mask_i,
  input  logic                next_round_i,
  output logic [SELW-1:0]     word_select_o,
  output logic [ALPHABET-1:0] guessed_mask_o,
  output logic [1:0]          game_state_o,
  output logic                wrong_o,
  output logic                repeat_guess_o,
  output logic [WW-1:0]       wrong_time_o,
  output logic [SCORE_W-1:0]  score_o
);

  localparam int LCW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [LCW-1:0]      LD_LAST   = (RAM_LAT > 0) ? LCW'(RAM_LAT - 1) : '0;
  localparam logic [SELW-1:0]     LAST_WORD = SELW'(NUM_WORDS - 1);
  localparam logic [WW-1:0]       WRONG_LIM = WW'(MAX_WRONG);
  localparam logic [ALPHABET-1:0] ONE_HOT0  = ALPHABET'(1);

  game_state_e         state_q, state_d;
  logic [LCW-1:0]      ld_cnt_q, ld_cnt_d;
  logic [SELW-1:0]     word_sel_q, word_sel_d;
  logic [ALPHABET-1:0] guessed_q, guessed_d;
  logic [WW-1:0]       wrong_time_q, wrong_time_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                wrong_q, wrong_d;
  logic                repeat_q, repeat_d;

  logic                load_ok;
  logic [ALPHABET-1:0] guess_oh;
  logic                timeout_hit;

  assign load_ok  = load_i && letter_in_range(32'(load_x_i), ALPHABET);
  // Out-of-range codes shift the bit out entirely; load_ok gates them anyway.
  assign guess_oh = ONE_HOT0 << load_x_i;

`ifdef HANGMAN_TIMEOUT_EN
  hangman_guess_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_guess_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .run_i     (state_q == ST_PLAY),
    .restart_i (load_ok),
    .expire_o  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    word_sel_d   = word_sel_q;
    guessed_d    = guessed_q;
    wrong_time_d = wrong_time_q;
    score_d      = score_q;
    wrong_d      = 1'b0;
    repeat_d     = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (ld_cnt_q >= LD_LAST) begin
          ld_cnt_d = '0;
          state_d  = ST_PLAY;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end

      ST_PLAY: begin
        if (load_ok) begin
          if ((guessed_q & guess_oh) != '0) begin
            repeat_d = 1'b1;
          end else begin
            guessed_d = guessed_q | guess_oh;
            if ((mask_i & guess_oh) == '0) begin
              wrong_d = 1'b1;
              if (wrong_time_q != '1) wrong_time_d = wrong_time_q + 1'b1;
            end
          end
        end else if (timeout_hit) begin
          wrong_d = 1'b1;
          if (wrong_time_q != '1) wrong_time_d = wrong_time_q + 1'b1;
        end

        // End check looks at registered values, so it trails a guess by one cycle.
        if (wrong_time_q >= WRONG_LIM) begin
          state_d = ST_LOSE;
        end else if ((mask_i & ~guessed_q) == '0) begin
          state_d = ST_WIN;
          if (score_q != '1) score_d = score_q + 1'b1;
        end
      end

      ST_WIN, ST_LOSE: begin
        if (next_round_i) begin
          word_sel_d   = (word_sel_q == LAST_WORD) ? '0 : word_sel_q + 1'b1;
          guessed_d    = '0;
          wrong_time_d = '0;
          ld_cnt_d     = '0;
          state_d      = ST_LOAD;
          if (state_q == ST_LOSE) score_d = '0;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_LOAD;
      ld_cnt_q     <= '0;
      word_sel_q   <= '0;
      guessed_q    <= '0;
      wrong_time_q <= '0;
      score_q      <= '0;
      wrong_q      <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      word_sel_q   <= word_sel_d;
      guessed_q    <= guessed_d;
      wrong_time_q <= wrong_time_d;
      score_q      <= score_d;
      wrong_q      <= wrong_d;
      repeat_q     <= repeat_d;
    end
  end

  assign word_select_o  = word_sel_q;
  assign guessed_mask_o = guessed_q;
  assign game_state_o   = state_q;
  assign wrong_o        = wrong_q;
  assign repeat_guess_o = repeat_q;
  assign wrong_time_o   = wrong_time_q;
  assign score_o        = score_q;

endmodule
